xif_coproc_dispatcher: RTL and testbench
========================================

# xif_coproc_dispatcher

Sequences one CORE-V-XIF offload at a time from the CV32E20 core across two coprocessors sharing the extension interface. It offers each offloaded instruction to coprocessor 0 first and, on rejection, to coprocessor 1. It then routes the commit to the accepting coprocessor and returns that coprocessor's result to the core. A result watchdog and stray-result detection cover misbehaving coprocessors.

## Interface
Parameters:
- X_ID_WIDTH, 4, instruction ID width
- X_RFR_WIDTH, 32, register operand width
- X_NUM_RS, 2, source operands per issue
- TIMEOUT_CYCLES, 256, result watchdog limit in cycles; 0 disables the watchdog

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cpu_issue_valid_i / cpu_issue_ready_o  in/out  1  core issue handshake
- cpu_issue_instr_i  in  32  offloaded instruction
- cpu_issue_id_i  in  X_ID_WIDTH  instruction ID
- cpu_issue_rs_i  in  X_NUM_RS*X_RFR_WIDTH  operands
- cpu_issue_rs_valid_i  in  X_NUM_RS  operand valid flags
- cpu_issue_accept_o, cpu_issue_writeback_o  out  1  issue response to core
- cpu_commit_valid_i, cpu_commit_kill_i  in  1  commit from core
- cpu_commit_id_i  in  X_ID_WIDTH  committed ID
- cpu_result_valid_o / cpu_result_ready_i  out/in  1  result handshake to core
- cpu_result_id_o, cpu_result_data_o, cpu_result_rd_o, cpu_result_we_o  out  X_ID_WIDTH, X_RFR_WIDTH, 5, 1  result payload
- cp_issue_valid_o  out  2  per-coprocessor issue valid
- cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i  in  2 each  per-coprocessor issue response
- cp_issue_instr_o, cp_issue_id_o, cp_issue_rs_o, cp_issue_rs_valid_o  out  same widths as core  broadcast copy of the core request
- cp_commit_valid_o  out  2  commit, routed to the owner only
- cp_commit_id_o  out  X_ID_WIDTH  registered ID of the in-flight instruction
- cp_commit_kill_o  out  1  copy of cpu_commit_kill_i
- cp_result_valid_i  in  2  per-coprocessor result valid
- cp_result_ready_o  out  2  per-coprocessor result ready
- cp_result_id_i, cp_result_data_i, cp_result_rd_i, cp_result_we_i  in  packed 2x  per-coprocessor result payload
- timeout_o  out  1  one-cycle pulse when the watchdog fires
- stray_result_o  out  1  registered flag for an unrouted result

## Operation
- The FSM has four states: TRY0 (reset state), TRY1, COMMIT, RESULT. Registered state: the FSM state, `owner` (1 bit), `id_q`, the watchdog counter, and stray_result_o.
- TRY0:
  - cp_issue_valid_o[0] = cpu_issue_valid_i.
  - On cp_issue_ready_i[0] with accept: cpu_issue_ready_o=1, accept_o=1, writeback_o=cp_issue_writeback_i[0], owner←0, id_q←cpu_issue_id_i, next state COMMIT.
  - On cp_issue_ready_i[0] with reject: the core is not acknowledged; next state TRY1.
- TRY1:
  - cp_issue_valid_o[1] = cpu_issue_valid_i. The core holds its request stable per XIF.
  - On cp_issue_ready_i[1]: cpu_issue_ready_o=1, accept_o=cp_issue_accept_i[1], writeback_o = writeback & accept.
  - If accepted: owner←1, capture the ID, next state COMMIT. If rejected: next state TRY0, and the core treats the instruction as illegal.
- COMMIT:
  - A commit with cpu_commit_id_i==id_q drives cp_commit_valid_o[owner]=1.
  - Kill: next state TRY0. No kill: next state RESULT and the watchdog counter clears.
  - A commit with a mismatched ID is dropped and not forwarded.
- A commit arriving in the same cycle as the accepting issue handshake is compared against cpu_issue_id_i. It is forwarded to the accepting coprocessor, and the FSM goes directly to TRY0 (kill) or RESULT.
- RESULT:
  - The cpu_result_* outputs mux the owner's payload. cp_result_ready_o[owner]=cpu_result_ready_i. The other ready is 0.
  - A handshake moves the FSM to TRY0.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: timeout_o=1 for one cycle, the FSM goes to TRY0, and no result is forwarded.
- Outside RESULT, all cp_result_ready_o are 0.
- Stray result: cp_result_valid_i[k] high while k is not the routed owner in RESULT. stray_result_o is asserted the next cycle and is combined across coprocessors.
- The counter saturates and never wraps.

## Timing
- Reset values: state TRY0; owner 0; id_q 0; counter 0; timeout_o 0; stray_result_o 0.
- With all inputs low, every output is 0.
- Combinational paths:
  - cpu_issue_valid_i → cp_issue_valid_o
  - cp_issue_ready_i → cpu_issue_ready_o
  - cpu_commit_* → cp_commit_*
  - cp_result_* → cpu_result_*, and cpu_result_ready_i → cp_result_ready_o
- Issue latency:
  - Accept by coprocessor 0: same cycle as its ready.
  - Accept by coprocessor 1: at least one extra cycle, because the coprocessor 0 reject is registered.
- Reset asserted mid-transaction returns all registers to reset values on the next edge. No handshake is completed in the reset cycle.

## Test plan
- Coprocessor 0 accepts ID 3 with writeback=1, commit without kill, result data 0xDEADBEEF with rd=5 → core sees accept=1 in cycle 0, then result id 3, data 0xDEADBEEF, rd 5, we 1. cp_result_ready_o[1] stays 0 throughout.
- Coprocessor 0 rejects, coprocessor 1 accepts ID 7 → cpu_issue_ready_o=1 exactly one cycle after the coprocessor 0 reject. The commit for ID 7 appears only on cp_commit_valid_o[1].
- Both coprocessors reject → accept_o=0 and writeback_o=0 on the coprocessor 1 ready. The FSM returns to TRY0, and a new issue goes to coprocessor 0.
- Accepted issue with a same-cycle commit_kill → commit is forwarded with kill=1, the FSM is in TRY0 the next cycle, and no result is awaited.
- TIMEOUT_CYCLES=4 with no result → timeout_o pulses once, 4 cycles after entering RESULT. A coprocessor 1 result_valid injected during COMMIT gives stray_result_o=1 the next cycle with its ready held 0.
- Reset asserted in RESULT with the result pending → all outputs 0 the next cycle. A following issue starts at coprocessor 0.

Source files
------------

// File: rtl/xif_coproc_dispatcher_if.sv
// Core-side and coprocessor-side CORE-V-XIF signals of the two-coprocessor dispatcher.
// Signal suffixes are relative to the dispatcher; fsm_state exposes the dispatcher FSM.
interface xif_coproc_dispatcher_if #(
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFR_WIDTH = 32,
   parameter int X_NUM_RS    = 2
);
   logic                            cpu_issue_valid_i;
   logic                            cpu_issue_ready_o;
   logic [31:0]                     cpu_issue_instr_i;
   logic [X_ID_WIDTH-1:0]           cpu_issue_id_i;
   logic [X_NUM_RS*X_RFR_WIDTH-1:0] cpu_issue_rs_i;
   logic [X_NUM_RS-1:0]             cpu_issue_rs_valid_i;
   logic                            cpu_issue_accept_o;
   logic                            cpu_issue_writeback_o;
   logic                            cpu_commit_valid_i;
   logic                            cpu_commit_kill_i;
   logic [X_ID_WIDTH-1:0]           cpu_commit_id_i;
   logic                            cpu_result_valid_o;
   logic                            cpu_result_ready_i;
   logic [X_ID_WIDTH-1:0]           cpu_result_id_o;
   logic [X_RFR_WIDTH-1:0]          cpu_result_data_o;
   logic [4:0]                      cpu_result_rd_o;
   logic                            cpu_result_we_o;

   logic [1:0]                      cp_issue_valid_o;
   logic [1:0]                      cp_issue_ready_i;
   logic [1:0]                      cp_issue_accept_i;
   logic [1:0]                      cp_issue_writeback_i;
   logic [31:0]                     cp_issue_instr_o;
   logic [X_ID_WIDTH-1:0]           cp_issue_id_o;
   logic [X_NUM_RS*X_RFR_WIDTH-1:0] cp_issue_rs_o;
   logic [X_NUM_RS-1:0]             cp_issue_rs_valid_o;
   logic [1:0]                      cp_commit_valid_o;
   logic [X_ID_WIDTH-1:0]           cp_commit_id_o;
   logic                            cp_commit_kill_o;
   logic [1:0]                      cp_result_valid_i;
   logic [1:0]                      cp_result_ready_o;
   logic [1:0][X_ID_WIDTH-1:0]      cp_result_id_i;
   logic [1:0][X_RFR_WIDTH-1:0]     cp_result_data_i;
   logic [1:0][4:0]                 cp_result_rd_i;
   logic [1:0]                      cp_result_we_i;

   logic                            timeout_o;
   logic                            stray_result_o;
   logic [1:0]                      fsm_state;

   modport slave (
      input  cpu_issue_valid_i, cpu_issue_instr_i, cpu_issue_id_i, cpu_issue_rs_i,
             cpu_issue_rs_valid_i, cpu_commit_valid_i, cpu_commit_kill_i, cpu_commit_id_i,
             cpu_result_ready_i, cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
             cp_result_valid_i, cp_result_id_i, cp_result_data_i, cp_result_rd_i, cp_result_we_i,
      output cpu_issue_ready_o, cpu_issue_accept_o, cpu_issue_writeback_o, cpu_result_valid_o,
             cpu_result_id_o, cpu_result_data_o, cpu_result_rd_o, cpu_result_we_o,
             cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o, cp_issue_rs_o, cp_issue_rs_valid_o,
             cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o, cp_result_ready_o,
             timeout_o, stray_result_o, fsm_state
   );

   modport master (
      output cpu_issue_valid_i, cpu_issue_instr_i, cpu_issue_id_i, cpu_issue_rs_i,
             cpu_issue_rs_valid_i, cpu_commit_valid_i, cpu_commit_kill_i, cpu_commit_id_i,
             cpu_result_ready_i, cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
             cp_result_valid_i, cp_result_id_i, cp_result_data_i, cp_result_rd_i, cp_result_we_i,
      input  cpu_issue_ready_o, cpu_issue_accept_o, cpu_issue_writeback_o, cpu_result_valid_o,
             cpu_result_id_o, cpu_result_data_o, cpu_result_rd_o, cpu_result_we_o,
             cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o, cp_issue_rs_o, cp_issue_rs_valid_o,
             cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o, cp_result_ready_o,
             timeout_o, stray_result_o, fsm_state
   );
endinterface

// File: rtl/xif_coproc_dispatcher.sv
// Dispatches one XIF offload at a time to coprocessor 0, falling back to coprocessor 1,
// then routes commit and result for the owner, with a result watchdog and stray detection.
module xif_coproc_dispatcher #(
   parameter int X_ID_WIDTH     = 4,
   parameter int X_RFR_WIDTH    = 32,
   parameter int X_NUM_RS       = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                    clk_i,
   input logic                    rst_i,
   xif_coproc_dispatcher_if.slave xif
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      TRY0   = 2'd0,
      TRY1   = 2'd1,
      COMMIT = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t                          state;
   logic                            owner;
   logic [X_ID_WIDTH-1:0]           id_q;
   logic [CW-1:0]                   cnt;
   logic                            timeout_q;
   logic                            stray_q;

   logic                            issue_acc;
   logic                            issue_rej;
   logic                            acc_cp;
   logic                            commit_fwd;
   logic                            commit_route;
   logic                            result_hs;
   logic [1:0]                      stray;
   logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_bcast;
   logic [X_RFR_WIDTH-1:0]          res_data;

   assign rs_bcast                 = xif.cpu_issue_rs_i;
   assign xif.cp_issue_rs_o        = rs_bcast;
   assign xif.cp_issue_instr_o     = xif.cpu_issue_instr_i;
   assign xif.cp_issue_id_o        = xif.cpu_issue_id_i;
   assign xif.cp_issue_rs_valid_o  = xif.cpu_issue_rs_valid_i;
   assign xif.cp_commit_kill_o     = xif.cpu_commit_kill_i;
   // A commit landing with the accepting issue handshake carries the live issue ID.
   assign xif.cp_commit_id_o       = (state == TRY0 || state == TRY1) ? xif.cpu_issue_id_i : id_q;
   assign xif.cpu_result_data_o    = res_data;
   assign xif.timeout_o            = timeout_q;
   assign xif.stray_result_o       = stray_q;
   assign xif.fsm_state            = state;
   assign stray = xif.cp_result_valid_i &
                  ~((state == RESULT) ? (owner ? 2'b10 : 2'b01) : 2'b00);

   // Handshakes use strict valid/ready: a transfer happens only in a cycle where both are
   // high; ready never waits on valid. Nothing handshakes while rst_i is high.
   always_comb begin
      xif.cp_issue_valid_o      = '0;
      xif.cpu_issue_ready_o     = 1'b0;
      xif.cpu_issue_accept_o    = 1'b0;
      xif.cpu_issue_writeback_o = 1'b0;
      xif.cp_commit_valid_o     = '0;
      xif.cpu_result_valid_o    = 1'b0;
      xif.cpu_result_id_o       = '0;
      res_data                  = '0;
      xif.cpu_result_rd_o       = '0;
      xif.cpu_result_we_o       = 1'b0;
      xif.cp_result_ready_o     = '0;
      issue_acc                 = 1'b0;
      issue_rej                 = 1'b0;
      acc_cp                    = 1'b0;
      commit_fwd                = 1'b0;
      commit_route              = owner;
      result_hs                 = 1'b0;
      if (!rst_i) begin
         case (state)
            TRY0: begin
               xif.cp_issue_valid_o[0]   = xif.cpu_issue_valid_i;
               xif.cpu_issue_ready_o     = xif.cp_issue_ready_i[0] & xif.cp_issue_accept_i[0];
               xif.cpu_issue_accept_o    = xif.cpu_issue_ready_o;
               xif.cpu_issue_writeback_o = xif.cpu_issue_ready_o & xif.cp_issue_writeback_i[0];
               issue_acc = xif.cpu_issue_valid_i & xif.cp_issue_ready_i[0] & xif.cp_issue_accept_i[0];
               issue_rej = xif.cpu_issue_valid_i & xif.cp_issue_ready_i[0] & ~xif.cp_issue_accept_i[0];
            end
            TRY1: begin
               xif.cp_issue_valid_o[1]   = xif.cpu_issue_valid_i;
               xif.cpu_issue_ready_o     = xif.cp_issue_ready_i[1];
               xif.cpu_issue_accept_o    = xif.cp_issue_ready_i[1] & xif.cp_issue_accept_i[1];
               xif.cpu_issue_writeback_o = xif.cpu_issue_accept_o & xif.cp_issue_writeback_i[1];
               issue_acc = xif.cpu_issue_valid_i & xif.cp_issue_ready_i[1] & xif.cp_issue_accept_i[1];
               issue_rej = xif.cpu_issue_valid_i & xif.cp_issue_ready_i[1] & ~xif.cp_issue_accept_i[1];
               acc_cp    = 1'b1;
            end
            COMMIT: begin
               commit_fwd = xif.cpu_commit_valid_i && (xif.cpu_commit_id_i == id_q);
            end
            RESULT: begin
               xif.cpu_result_valid_o       = xif.cp_result_valid_i[owner];
               xif.cpu_result_id_o          = xif.cp_result_id_i[owner];
               res_data                     = xif.cp_result_data_i[owner];
               xif.cpu_result_rd_o          = xif.cp_result_rd_i[owner];
               xif.cpu_result_we_o          = xif.cp_result_we_i[owner];
               xif.cp_result_ready_o[owner] = xif.cpu_result_ready_i;
               result_hs = xif.cp_result_valid_i[owner] & xif.cpu_result_ready_i;
            end
            default: ;
         endcase
         if (issue_acc && xif.cpu_commit_valid_i && (xif.cpu_commit_id_i == xif.cpu_issue_id_i)) begin
            commit_fwd   = 1'b1;
            commit_route = acc_cp;
         end
         xif.cp_commit_valid_o[commit_route] = commit_fwd;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= TRY0;
         owner     <= 1'b0;
         id_q      <= '0;
         cnt       <= '0;
         timeout_q <= 1'b0;
         stray_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         stray_q   <= |stray;
         case (state)
            TRY0, TRY1: begin
               if (issue_acc) begin
                  owner <= acc_cp;
                  id_q  <= xif.cpu_issue_id_i;
                  cnt   <= '0;
                  if (commit_fwd) state <= xif.cpu_commit_kill_i ? TRY0 : RESULT;
                  else            state <= COMMIT;
               end else if (issue_rej) begin
                  state <= (state == TRY0) ? TRY1 : TRY0;
               end
            end
            COMMIT: begin
               if (commit_fwd) begin
                  state <= xif.cpu_commit_kill_i ? TRY0 : RESULT;
                  cnt   <= '0;
               end
            end
            RESULT: begin
               if (result_hs) begin
                  state <= TRY0;
               end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                  timeout_q <= 1'b1;
                  state     <= TRY0;
               end else if (cnt != {CW{1'b1}}) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= TRY0;
         endcase
      end
   end
endmodule

// File: tb/tb_xif_coproc_dispatcher.sv
// Directed bench for xif_coproc_dispatcher: stimulus pushes expected responses into
// queues that an independent negedge monitor pops whenever the DUT presents a transfer.
module tb_xif_coproc_dispatcher;
   localparam int IDW = 4;
   localparam int RW  = 32;
   localparam int NRS = 2;
   localparam int TO  = 4;
   localparam logic [1:0] S_TRY0   = 2'd0;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_RESULT = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xif_coproc_dispatcher_if #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .X_NUM_RS(NRS)) xif ();

   xif_coproc_dispatcher #(
      .X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .X_NUM_RS(NRS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .xif  (xif)
   );

   int n_vec = 0;
   int n_mis = 0;
   logic [1:0]  iss_q[$];  // {accept, writeback}
   logic [6:0]  cmt_q[$];  // {cp_commit_valid[1:0], kill, id}
   logic [41:0] res_q[$];  // {id, data, rd, we}
   logic [1:0]  evt_q[$];  // {timeout, stray}

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_mis++;
      $display("FAIL %s: DUT presented a transfer with no expected entry queued", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      xif.cpu_issue_valid_i    = 1'b0;
      xif.cpu_issue_instr_i    = '0;
      xif.cpu_issue_id_i       = '0;
      xif.cpu_issue_rs_i       = '0;
      xif.cpu_issue_rs_valid_i = '0;
      xif.cpu_commit_valid_i   = 1'b0;
      xif.cpu_commit_kill_i    = 1'b0;
      xif.cpu_commit_id_i      = '0;
      xif.cpu_result_ready_i   = 1'b0;
      xif.cp_issue_ready_i     = '0;
      xif.cp_issue_accept_i    = '0;
      xif.cp_issue_writeback_i = '0;
      xif.cp_result_valid_i    = '0;
      xif.cp_result_id_i       = '0;
      xif.cp_result_data_i     = '0;
      xif.cp_result_rd_i       = '0;
      xif.cp_result_we_i       = '0;
   endtask

   task automatic issue(input logic [3:0] id, input logic [1:0] rdy, input logic [1:0] acc,
                        input logic [1:0] wb);
      xif.cpu_issue_valid_i    = 1'b1;
      xif.cpu_issue_id_i       = id;
      xif.cpu_issue_instr_i    = {28'h00A0B0C, id};
      xif.cpu_issue_rs_i       = {28'h1111111, id, 28'h2222222, id};
      xif.cpu_issue_rs_valid_i = 2'b11;
      xif.cp_issue_ready_i     = rdy;
      xif.cp_issue_accept_i    = acc;
      xif.cp_issue_writeback_i = wb;
   endtask

   task automatic commit(input logic kill, input logic [3:0] id);
      xif.cpu_commit_valid_i = 1'b1;
      xif.cpu_commit_kill_i  = kill;
      xif.cpu_commit_id_i    = id;
   endtask

   task automatic result(input int k, input logic [3:0] id, input logic [31:0] data,
                         input logic [4:0] rd, input logic we);
      xif.cp_result_valid_i[k] = 1'b1;
      xif.cp_result_id_i[k]    = id;
      xif.cp_result_data_i[k]  = data;
      xif.cp_result_rd_i[k]    = rd;
      xif.cp_result_we_i[k]    = we;
   endtask

   function automatic logic any_output();
      return |{xif.cpu_issue_ready_o, xif.cpu_issue_accept_o, xif.cpu_issue_writeback_o,
               xif.cpu_result_valid_o, xif.cpu_result_id_o, xif.cpu_result_data_o,
               xif.cpu_result_rd_o, xif.cpu_result_we_o, xif.cp_issue_valid_o,
               xif.cp_issue_instr_o, xif.cp_issue_id_o, xif.cp_issue_rs_o,
               xif.cp_issue_rs_valid_o, xif.cp_commit_valid_o, xif.cp_commit_id_o,
               xif.cp_commit_kill_o, xif.cp_result_ready_o, xif.timeout_o,
               xif.stray_result_o, xif.fsm_state};
   endfunction

   // Monitor: pops and compares every transfer the DUT presents.
   initial begin
      forever begin
         @(negedge clk);
         if (xif.cpu_issue_valid_i && xif.cpu_issue_ready_o) begin
            if (iss_q.size() == 0) unexpected("issue_resp");
            else check("issue_resp", 64'({xif.cpu_issue_accept_o, xif.cpu_issue_writeback_o}),
                       64'(iss_q.pop_front()));
         end
         if (xif.cp_commit_valid_o != 2'b00) begin
            if (cmt_q.size() == 0) unexpected("commit_fwd");
            else check("commit_fwd",
                       64'({xif.cp_commit_valid_o, xif.cp_commit_kill_o, xif.cp_commit_id_o}),
                       64'(cmt_q.pop_front()));
         end
         if (xif.cpu_result_valid_o && xif.cpu_result_ready_i) begin
            if (res_q.size() == 0) unexpected("result");
            else check("result", 64'({xif.cpu_result_id_o, xif.cpu_result_data_o,
                                      xif.cpu_result_rd_o, xif.cpu_result_we_o}),
                       64'(res_q.pop_front()));
         end
         if (xif.timeout_o || xif.stray_result_o) begin
            if (evt_q.size() == 0) unexpected("event");
            else check("event", 64'({xif.timeout_o, xif.stray_result_o}), 64'(evt_q.pop_front()));
         end
      end
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      check("reset_outputs_zero", 64'(any_output()), 64'(0));
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("idle_outputs_zero", 64'(any_output()), 64'(0));
      step();

      // cop0 accepts ID 3 with writeback, commit, result DEADBEEF rd 5
      issue(4'd3, 2'b01, 2'b01, 2'b01);
      iss_q.push_back(2'b11);
      @(negedge clk);
      check("t1_ready_cycle0", 64'(xif.cpu_issue_ready_o), 64'(1));
      check("t1_instr_bcast", 64'(xif.cp_issue_instr_o), 64'(32'h00A0B0C3));
      step();
      clear_inputs();
      commit(1'b0, 4'd3);
      cmt_q.push_back({2'b01, 1'b0, 4'd3});
      @(negedge clk);
      check("t1_rdy_in_commit", 64'(xif.cp_result_ready_o), 64'(0));
      step();
      clear_inputs();
      result(0, 4'd3, 32'hDEADBEEF, 5'd5, 1'b1);
      result(1, 4'd9, 32'h0BADF00D, 5'd17, 1'b0);
      xif.cp_result_valid_i[1] = 1'b0;
      xif.cpu_result_ready_i = 1'b1;
      res_q.push_back({4'd3, 32'hDEADBEEF, 5'd5, 1'b1});
      @(negedge clk);
      check("t1_result_ready", 64'(xif.cp_result_ready_o), 64'(2'b01));
      step();
      clear_inputs();

      // cop0 rejects, cop1 accepts ID 7; mismatched commit dropped
      issue(4'd7, 2'b01, 2'b00, 2'b00);
      @(negedge clk);
      check("t2_no_ack_on_reject", 64'(xif.cpu_issue_ready_o), 64'(0));
      step();
      issue(4'd7, 2'b10, 2'b10, 2'b00);
      iss_q.push_back(2'b10);
      @(negedge clk);
      check("t2_ready_next_cycle", 64'(xif.cpu_issue_ready_o), 64'(1));
      check("t2_cp1_valid", 64'(xif.cp_issue_valid_o), 64'(2'b10));
      step();
      clear_inputs();
      commit(1'b0, 4'd6);
      @(negedge clk);
      check("t2_mismatch_drop", 64'(xif.cp_commit_valid_o), 64'(0));
      step();
      commit(1'b0, 4'd7);
      cmt_q.push_back({2'b10, 1'b0, 4'd7});
      step();
      clear_inputs();
      result(1, 4'd7, 32'h12345678, 5'd9, 1'b0);
      xif.cpu_result_ready_i = 1'b1;
      res_q.push_back({4'd7, 32'h12345678, 5'd9, 1'b0});
      @(negedge clk);
      check("t2_result_ready", 64'(xif.cp_result_ready_o), 64'(2'b10));
      step();
      clear_inputs();

      // both reject, then a new issue goes to cop0 (killed at commit)
      issue(4'd2, 2'b01, 2'b00, 2'b00);
      step();
      issue(4'd2, 2'b10, 2'b00, 2'b10);
      iss_q.push_back(2'b00);
      step();
      issue(4'd5, 2'b01, 2'b01, 2'b00);
      iss_q.push_back(2'b10);
      @(negedge clk);
      check("t3_back_to_try0", 64'(xif.fsm_state), 64'(S_TRY0));
      check("t3_cp0_valid", 64'(xif.cp_issue_valid_o), 64'(2'b01));
      step();
      clear_inputs();
      commit(1'b1, 4'd5);
      cmt_q.push_back({2'b01, 1'b1, 4'd5});
      step();
      clear_inputs();

      // same-cycle commit: kill via cop0, then no-kill via cop1
      issue(4'hB, 2'b01, 2'b01, 2'b01);
      commit(1'b1, 4'hB);
      iss_q.push_back(2'b11);
      cmt_q.push_back({2'b01, 1'b1, 4'hB});
      step();
      clear_inputs();
      @(negedge clk);
      check("t4_kill_try0", 64'(xif.fsm_state), 64'(S_TRY0));
      step();
      issue(4'hC, 2'b01, 2'b00, 2'b00);
      step();
      issue(4'hC, 2'b10, 2'b10, 2'b10);
      commit(1'b0, 4'hC);
      iss_q.push_back(2'b11);
      cmt_q.push_back({2'b10, 1'b0, 4'hC});
      step();
      clear_inputs();
      result(1, 4'hC, 32'hCAFE0001, 5'd31, 1'b1);
      xif.cpu_result_ready_i = 1'b1;
      res_q.push_back({4'hC, 32'hCAFE0001, 5'd31, 1'b1});
      @(negedge clk);
      check("t4_direct_result", 64'(xif.fsm_state), 64'(S_RESULT));
      step();
      clear_inputs();

      // watchdog (TO=4) with a stray cop1 result during COMMIT
      issue(4'd9, 2'b01, 2'b01, 2'b00);
      iss_q.push_back(2'b10);
      step();
      clear_inputs();
      commit(1'b0, 4'd9);
      xif.cp_result_valid_i = 2'b10;
      cmt_q.push_back({2'b01, 1'b0, 4'd9});
      evt_q.push_back(2'b01);
      @(negedge clk);
      check("t5_stray_ready_low", 64'(xif.cp_result_ready_o), 64'(0));
      step();
      clear_inputs();
      xif.cpu_result_ready_i = 1'b1;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         check("t5_no_early_timeout", 64'({xif.timeout_o, xif.fsm_state}), 64'({1'b0, S_RESULT}));
         step();
      end
      evt_q.push_back(2'b10);
      @(negedge clk);
      check("t5_timeout_pulse", 64'(xif.timeout_o), 64'(1));
      check("t5_after_timeout", 64'({xif.fsm_state, xif.cp_result_ready_o}), 64'({S_TRY0, 2'b00}));
      step();
      @(negedge clk);
      check("t5_pulse_single", 64'(xif.timeout_o), 64'(0));
      step();
      clear_inputs();

      // reset while a result is pending
      issue(4'd4, 2'b01, 2'b01, 2'b00);
      iss_q.push_back(2'b10);
      step();
      clear_inputs();
      commit(1'b0, 4'd4);
      cmt_q.push_back({2'b01, 1'b0, 4'd4});
      @(negedge clk);
      check("t6_in_commit", 64'(xif.fsm_state), 64'(S_COMMIT));
      step();
      clear_inputs();
      result(0, 4'd4, 32'h55AA55AA, 5'd1, 1'b1);
      @(negedge clk);
      check("t6_pending", 64'(xif.cpu_result_valid_o), 64'(1));
      step();
      rst = 1'b1;
      xif.cpu_result_ready_i = 1'b1;
      @(negedge clk);
      check("t6_no_hs_in_reset", 64'(xif.cp_result_ready_o), 64'(0));
      step();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      check("t6_outputs_zero", 64'(any_output()), 64'(0));
      step();
      issue(4'd1, 2'b01, 2'b01, 2'b00);
      iss_q.push_back(2'b10);
      @(negedge clk);
      check("t6_restart_cp0", 64'(xif.cp_issue_valid_o), 64'(2'b01));
      step();
      clear_inputs();
      commit(1'b1, 4'd1);
      cmt_q.push_back({2'b01, 1'b1, 4'd1});
      step();
      clear_inputs();
      step();
      @(negedge clk);

      check("iss_q_drained", 64'(iss_q.size()), 64'(0));
      check("cmt_q_drained", 64'(cmt_q.size()), 64'(0));
      check("res_q_drained", 64'(res_q.size()), 64'(0));
      check("evt_q_drained", 64'(evt_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
